spmv_multiplier: RTL

- Upstream neighbour of the SpMV accumulator.
- Pops one nonzero per cycle from three input FIFOs: matrix value, column index and row index.
- Reads the dense vector element x[col] from a vector RAM and multiplies it by the value.
- Pushes the product into the mult FIFO and the row index into the row_id FIFO, both consumed by the accumulator.
- Fully pipelined, 1 nonzero/cycle throughput, with backpressure from the output FIFOs via almost-full flags.

---
 rtl/spmv_multiplier_if.sv | 39 +++
 rtl/spmv_multiplier.sv | 62 ++++++
 2 files changed

// File: rtl/spmv_multiplier_if.sv
// spmv_multiplier_if: input FIFOs, vector RAM, output FIFOs and status of the SpMV multiplier
interface spmv_multiplier_if #(
  parameter int VAL_BITS  = 16,
  parameter int COL_BITS  = 10,
  parameter int ROW_BITS  = 10,
  parameter int MULT_BITS = 32
);
  logic [VAL_BITS-1:0]  val_out;
  logic                 val_empty;
  logic                 val_rd_en;
  logic [COL_BITS-1:0]  col_out;
  logic                 col_empty;
  logic                 col_rd_en;
  logic [ROW_BITS-1:0]  row_out;
  logic                 row_empty;
  logic                 row_rd_en;
  logic [COL_BITS-1:0]  vec_addr;
  logic [VAL_BITS-1:0]  vec_data;
  logic [MULT_BITS-1:0] mult_din;
  logic                 mult_wr_en;
  logic                 mult_afull;
  logic [ROW_BITS-1:0]  row_id_din;
  logic                 row_id_wr_en;
  logic                 row_id_afull;
  logic [31:0]          nnz_count;
  logic                 busy;
  modport master (
    input  val_out, val_empty, col_out, col_empty, row_out, row_empty,
           vec_data, mult_afull, row_id_afull,
    output val_rd_en, col_rd_en, row_rd_en, vec_addr, mult_din, mult_wr_en,
           row_id_din, row_id_wr_en, nnz_count, busy
  );
  modport slave (
    output val_out, val_empty, col_out, col_empty, row_out, row_empty,
           vec_data, mult_afull, row_id_afull,
    input  val_rd_en, col_rd_en, row_rd_en, vec_addr, mult_din, mult_wr_en,
           row_id_din, row_id_wr_en, nnz_count, busy
  );
endinterface

// File: rtl/spmv_multiplier.sv
// spmv_multiplier: pops (val,col,row) nonzeros, multiplies val by x[col], pushes product+row 3 cycles later; MULT_SIGNED_EN selects a signed multiply
module spmv_multiplier #(
  parameter int VAL_BITS  = 16,
  parameter int COL_BITS  = 10,
  parameter int ROW_BITS  = 10,
  parameter int MULT_BITS = 32
) (
  input logic Clk,
  input logic Reset,
  spmv_multiplier_if.master bus
);
  logic                  pop, v1, v2, wr;
  logic [VAL_BITS-1:0]   val1, val2;
  logic [ROW_BITS-1:0]   row1, row2;
  logic [2*VAL_BITS-1:0] prod;
  logic [MULT_BITS-1:0]  prod_ext;
  logic [31:0]           nnz;
`ifdef MULT_SIGNED_EN
  assign prod = {{VAL_BITS{val2[VAL_BITS-1]}}, val2} * {{VAL_BITS{bus.vec_data[VAL_BITS-1]}}, bus.vec_data};
  assign prod_ext = MULT_BITS'($signed(prod));
`else
  assign prod = {{VAL_BITS{1'b0}}, val2} * {{VAL_BITS{1'b0}}, bus.vec_data};
  assign prod_ext = MULT_BITS'(prod);
`endif
  // Empty flags look ahead over the pop in progress, so a registered pop never underflows
  always_ff @(posedge Clk) begin
    if (Reset) begin
      pop            <= 1'b0;
      v1             <= 1'b0;
      v2             <= 1'b0;
      wr             <= 1'b0;
      val1           <= '0;
      val2           <= '0;
      row1           <= '0;
      row2           <= '0;
      nnz            <= '0;
      bus.vec_addr   <= '0;
      bus.mult_din   <= '0;
      bus.row_id_din <= '0;
    end else begin
      pop <= ~(bus.val_empty | bus.col_empty | bus.row_empty | bus.mult_afull | bus.row_id_afull);
      v1  <= pop;
      v2  <= v1;
      wr  <= v2;
      nnz <= nnz + {31'd0, wr};
      bus.vec_addr   <= pop ? bus.col_out : bus.vec_addr;
      val1           <= pop ? bus.val_out : val1;
      row1           <= pop ? bus.row_out : row1;
      val2           <= v1 ? val1 : val2;
      row2           <= v1 ? row1 : row2;
      bus.mult_din   <= v2 ? prod_ext : bus.mult_din;
      bus.row_id_din <= v2 ? row2 : bus.row_id_din;
    end
  end
  assign bus.val_rd_en    = pop;
  assign bus.col_rd_en    = pop;
  assign bus.row_rd_en    = pop;
  assign bus.mult_wr_en   = wr;
  assign bus.row_id_wr_en = wr;
  assign bus.nnz_count    = nnz;
  assign bus.busy         = pop | v1 | v2 | wr;
endmodule
